// File: rtl/pe_relu_bwd.sv
// pe_relu_bwd: records forward ReLU masks in a 1-bit FIFO and gates returning gradients with them.
module pe_relu_bwd #(
  parameter int W = 24,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fwd_valid,
  output logic                       fwd_ready,
  input  logic [W-1:0]               fwd_din,
  input  logic                       grad_valid,
  output logic                       grad_ready,
  input  logic [W-1:0]               grad_din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [15:0]                zero_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic push, pop, mask;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign fwd_ready = !rst && !flush && !full;
  assign grad_ready = !rst && !flush && !empty && (!out_valid || out_ready);
  assign push = fwd_valid && fwd_ready;
  assign pop = grad_valid && grad_ready;
  assign mask = mem[rp];
  // Mask storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk)
    if (push) mem[wp] <= ~fwd_din[W-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      out_valid <= 1'b0;
      out_dout <= '0;
      zero_cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      out_valid <= 1'b0;
      zero_cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      out_valid <= pop ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      if (pop) out_dout <= mask ? grad_din : '0;
      if (pop && !mask && zero_cnt != 16'hFFFF) zero_cnt <= zero_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pe_relu_bwd.sv
// tb_pe_relu_bwd: directed vector table plus hand-written sequences for pe_relu_bwd.
module tb_pe_relu_bwd;
  localparam int W = 24;
  localparam int DEPTH = 64;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 0, rst = 1, flush = 0, fwd_valid = 0, grad_valid = 0, out_ready = 1;
  logic [W-1:0] fwd_din = '0, grad_din = '0;
  logic fwd_ready, grad_ready, out_valid, empty, full;
  logic [W-1:0] out_dout;
  logic [CW-1:0] count;
  logic [15:0] zero_cnt;
  int checks = 0, errors = 0;
  typedef struct { logic [W-1:0] fwd, grad, exp; } vec_t;
  vec_t v[6];

  pe_relu_bwd #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_din(fwd_din),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_din(grad_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_dout(out_dout),
    .count(count), .empty(empty), .full(full), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  initial begin
    v[0] = '{24'd5, 24'd100, 24'd100};
    v[1] = '{-24'sd3, 24'd200, 24'd0};
    v[2] = '{24'd0, -24'sd300, -24'sd300};
    v[3] = '{24'h800000, 24'd400, 24'd0};
    v[4] = '{24'h7FFFFF, 24'h800000, 24'h800000};
    v[5] = '{-24'sd1, 24'h7FFFFF, 24'd0};
    // reset
    step();
    step();
    chk("rst_fwd_ready", fwd_ready, 0);
    chk("rst_grad_ready", grad_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_dout", out_dout, 0);
    chk("rst_zero_cnt", zero_cnt, 0);
    rst = 0;
    #1;
    chk("post_rst_fwd_ready", fwd_ready, 1);
    chk("post_rst_grad_ready", grad_ready, 0);
    // mask capture and gating from the vector table
    fwd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      fwd_din = v[i].fwd;
      step();
    end
    fwd_valid = 0;
    chk("mask_count", count, 6);
    grad_valid = 1;
    for (int i = 0; i < 6; i++) begin
      grad_din = v[i].grad;
      step();
      chk("mask_valid", out_valid, 1);
      chk("mask_dout", out_dout, v[i].exp);
    end
    grad_valid = 0;
    step();
    chk("mask_valid_drop", out_valid, 0);
    chk("mask_zero_cnt", zero_cnt, 3);
    chk("mask_empty", empty, 1);
    // fill to full from a non-zero pointer so the pointers wrap
    fwd_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_din = W'(i);
      step();
    end
    chk("full_flag", full, 1);
    chk("full_fwd_ready", fwd_ready, 0);
    chk("full_count", count, DEPTH);
    fwd_din = '1;
    step();
    chk("full_ignored", count, DEPTH);
    fwd_valid = 0;
    grad_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      grad_din = W'(i + 1);
      step();
      chk("drain_dout", out_dout, W'(i + 1));
    end
    chk("drain_empty", empty, 1);
    chk("drain_grad_ready", grad_ready, 0);
    step();
    chk("empty_no_accept", out_valid, 0);
    chk("empty_no_accept_dout", out_dout, DEPTH);
    grad_valid = 0;
    // second fill/drain with alternating signs
    fwd_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_din = i[0] ? '1 : W'(i);
      step();
    end
    fwd_valid = 0;
    grad_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      grad_din = W'(1000 + i);
      step();
      chk("alt_dout", out_dout, i[0] ? '0 : W'(1000 + i));
    end
    grad_valid = 0;
    step();
    chk("alt_empty", empty, 1);
    // simultaneous push and pop at count=1
    fwd_valid = 1;
    fwd_din = -24'sd5;
    step();
    fwd_din = 24'd5;
    grad_valid = 1;
    grad_din = 24'd11;
    step();
    chk("simul_count", count, 1);
    chk("simul_dout0", out_dout, 0);
    fwd_valid = 0;
    grad_din = 24'd22;
    step();
    chk("simul_dout1", out_dout, 22);
    chk("simul_count0", count, 0);
    grad_valid = 0;
    // push refused while full even with a same-cycle pop
    fwd_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_din = W'(i + 1);
      step();
    end
    fwd_din = 24'd3;
    grad_valid = 1;
    grad_din = 24'd9;
    #1;
    chk("fullpop_fwd_ready", fwd_ready, 0);
    step();
    chk("fullpop_count", count, DEPTH - 1);
    chk("fullpop_dout", out_dout, 9);
    fwd_valid = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      grad_din = W'(500 + i);
      step();
      chk("fullpop_drain", out_dout, W'(500 + i));
    end
    chk("fullpop_empty", empty, 1);
    grad_valid = 0;
    step();
    // backpressure
    fwd_valid = 1;
    fwd_din = 24'd1;
    for (int i = 0; i < 3; i++) step();
    fwd_valid = 0;
    grad_valid = 1;
    grad_din = 24'd7;
    step();
    chk("bp_first", out_dout, 7);
    out_ready = 0;
    grad_din = 24'd8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_dout", out_dout, 7);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_grad_ready", grad_ready, 0);
      chk("bp_count", count, 2);
    end
    out_ready = 1;
    step();
    chk("bp_rel1", out_dout, 8);
    grad_din = 24'd9;
    step();
    chk("bp_rel2", out_dout, 9);
    chk("bp_rel_count", count, 0);
    grad_valid = 0;
    step();
    chk("bp_end_valid", out_valid, 0);
    chk("bp_end_dout", out_dout, 9);
    // flush mid-stream with count=10 and a pending output
    fwd_valid = 1;
    fwd_din = 24'd2;
    step();
    fwd_din = '1;
    for (int i = 0; i < 10; i++) step();
    fwd_valid = 0;
    grad_valid = 1;
    grad_din = 24'd55;
    step();
    chk("fl_pre_count", count, 10);
    chk("fl_pre_valid", out_valid, 1);
    flush = 1;
    fwd_valid = 1;
    fwd_din = 24'd4;
    grad_din = 24'd66;
    #1;
    chk("fl_fwd_ready", fwd_ready, 0);
    chk("fl_grad_ready", grad_ready, 0);
    step();
    flush = 0;
    fwd_valid = 0;
    grad_valid = 0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_valid", out_valid, 0);
    chk("fl_zero_cnt", zero_cnt, 0);
    chk("fl_dout_hold", out_dout, 55);
    // zero_cnt saturation: 65537 zeroed pops
    fwd_valid = 1;
    fwd_din = '1;
    grad_valid = 1;
    grad_din = 24'd1;
    for (int k = 1; k <= 65538; k++) begin
      step();
      if (k == 1001) chk("sat_partial", zero_cnt, 1000);
    end
    chk("sat_zero_cnt", zero_cnt, 16'hFFFF);
    fwd_valid = 0;
    step();
    chk("sat_hold", zero_cnt, 16'hFFFF);
    chk("sat_empty", empty, 1);
    grad_valid = 0;
    // reset mid-stream with a pending output
    fwd_valid = 1;
    fwd_din = 24'd5;
    step();
    fwd_valid = 0;
    out_ready = 0;
    grad_valid = 1;
    grad_din = 24'd77;
    step();
    grad_valid = 0;
    fwd_valid = 1;
    for (int i = 0; i < 2; i++) step();
    fwd_valid = 0;
    chk("mr_pre_dout", out_dout, 77);
    chk("mr_pre_count", count, 2);
    rst = 1;
    #1;
    chk("mr_fwd_ready", fwd_ready, 0);
    chk("mr_grad_ready", grad_ready, 0);
    step();
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_dout", out_dout, 0);
    chk("mr_zero_cnt", zero_cnt, 0);
    rst = 0;
    out_ready = 1;
    #1;
    chk("mr_post_fwd_ready", fwd_ready, 1);
    chk("mr_post_grad_ready", grad_ready, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_relu_bwd.md
# pe_relu_bwd

Backward-pass companion to the PE ReLU stage.
- **Forward pass:** records one mask bit per activation, set when the pre-activation sign bit is clear. This matches forward ReLU, which passes any non-negative value, zero included.
- **Backward pass:** multiplies each incoming gradient by its recorded mask bit. The gradient passes when the bit is set and is replaced by zero otherwise.

Sits between the PE output path (forward, mask capture) and the gradient return path (backward) of the training datapath. All three streams use valid/ready handshakes.

## Interface
- W, 24, gradient and pre-activation data width (signed two's complement)
- DEPTH, 64, mask buffer capacity in entries; power of two, at least 2
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous clear of mask buffer and output stage
- fwd_valid  input  1  forward pre-activation valid
- fwd_ready  output  1  mask buffer can accept a bit
- fwd_din  input  W  forward pre-activation (signed); only bit W-1 is used
- grad_valid  input  1  incoming gradient valid
- grad_ready  output  1  gradient can be accepted
- grad_din  input  W  incoming gradient (signed)
- out_valid  output  1  gated gradient valid
- out_ready  input  1  downstream accepts gated gradient
- out_dout  output  W  gated gradient (signed)
- count  output  $clog2(DEPTH+1)  mask entries currently held
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- zero_cnt  output  16  number of gradients forced to zero since reset or flush; saturates at 16'hFFFF

## Operation
- **Mask buffer:** a DEPTH-entry, 1-bit circular FIFO with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- **Push:** happens when fwd_valid && fwd_ready. The value written is ~fwd_din[W-1].
- **Pop:** happens when grad_valid && grad_ready. It reads the oldest mask bit.
- **fwd_ready** = !rst && !flush && !full.
  - When full, a push is refused even if a pop happens in the same cycle.
- **grad_ready** = !rst && !flush && !empty && (!out_valid || out_ready).
  - There is no same-cycle bypass: a bit pushed in cycle N can be popped at the earliest in cycle N+1.
- **Simultaneous push and pop:** both pointers advance and count is unchanged.
- **Output register:**
  - On a pop, out_dout <= mask ? grad_din : 0 and out_valid <= 1.
  - When mask == 0, zero_cnt increments, saturating.
  - A mask of 1 passes grad_din bit-exact. There is no arithmetic and no width change.
- **Output hold:** with out_valid && !out_ready, out_dout and out_valid hold and grad_ready is 0.
  - With out_valid && out_ready and no new pop, out_valid <= 0 and out_dout holds its last value.
- **flush:**
  - Clears pointers, count, out_valid and zero_cnt in the next cycle. out_dout holds.
  - Takes priority over any handshake in the same cycle: no push or pop occurs.
  - An output word pending at flush is dropped.
- **Gradient with nothing to pair against:** grad_valid while empty is not accepted, because grad_ready is 0. The producer waits.

## Timing
- **Reset values** (the cycle after rst is sampled high): count=0, empty=1, full=0, out_valid=0, out_dout=0, zero_cnt=0.
  - fwd_ready=1 and grad_ready=0 once rst deasserts. Both readies are 0 while rst is high.
- **Reset mid-operation:** all buffered masks and any pending output are discarded, identically to flush.
- **Latency:** a gradient accepted in cycle N appears on out_dout/out_valid in cycle N+1.
- **Throughput:** one gradient per cycle while out_ready=1 and count>0. One push per cycle while not full.
- **Status outputs:** count, empty and full reflect registered state and update the cycle after a push or pop.
- **zero_cnt:** updates in the same cycle that out_valid rises for a zeroed word.

## Test plan
- **Mask capture and gating.**
  - Stimulus: push fwd_din = 5, -3, 0, -8388608 (W=24), then gradients 100, 200, -300, 400 with out_ready=1.
  - Required: out_dout = 100, 0, -300, 0 on consecutive cycles, each one cycle after acceptance; zero_cnt=2.
- **Full and empty boundary.**
  - Stimulus: push DEPTH non-negative values.
  - Required: full=1 and fwd_ready=0 after the 64th push, and a further fwd_valid is ignored.
  - Stimulus: pop all entries.
  - Required: empty=1 and grad_ready=0; pointer wrap is verified by a second fill/drain with an alternating sign pattern.
- **Simultaneous push and pop at count=1.**
  - Required: count stays 1 and FIFO order is preserved.
  - Stimulus: push while full with a same-cycle pop.
  - Required: the push is refused and count becomes DEPTH-1.
- **Backpressure.**
  - Stimulus: hold out_ready=0 for 5 cycles with gradients pending.
  - Required: out_dout stable, grad_ready=0, count unchanged; after release, words drain one per cycle with none lost or duplicated.
- **flush mid-stream.**
  - Stimulus: count=10 with out_valid=1, assert flush together with fwd_valid and grad_valid.
  - Required: next cycle count=0, empty=1, out_valid=0, zero_cnt=0; no push or pop recorded.
- **Saturation and reset.**
  - Stimulus: force 65537 zeroed gradients.
  - Required: zero_cnt=16'hFFFF.
  - Stimulus: assert rst mid-stream.
  - Required: all outputs reach their reset values one cycle later.
